microwave_controller: RTL and testbench

- Top-level sequencer for the microwave cook timer.
- Accepts keypad digit strobes (BCD digit + load) and shifts them into an M:SS time register.
- Runs a start/stop/pause/door-interlock FSM and counts the time down on the 1 Hz tick.
- Drives magnetron enable, BCD display digits and the done indication.
- Sits between the keypad encoder outputs (D, load, pgt_1Hz) and the display/magnetron drivers.

---
 rtl/microwave_pkg.sv | 18 +
 rtl/microwave_controller_time.sv | 54 +++++
 rtl/microwave_controller.sv | 134 +++++++++++++
 tb/tb_microwave_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-timer controller.
package microwave_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t BCD_MAX      = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COOK   = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/microwave_controller_time.sv
// bcd_time_reg: M:SS BCD time register with keypad shift-in, borrow decrement
// and zero detection. Operation priority: clr_en > shift_en > dec_en.
module bcd_time_reg
  import microwave_pkg::*;
#(
  parameter int unsigned MAX_MIN = 9
) (
  input  logic clk,
  input  logic clear,
  input  logic clr_en,
  input  logic shift_en,
  input  bcd_t digit,
  input  logic dec_en,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output logic shift_ok,
  output logic zero,
  output logic dec_to_zero
);

  localparam bcd_t MIN_MAX_D = bcd_t'(MAX_MIN);

  // After a shift, sec_ones becomes sec_tens and sec_tens becomes min_ones.
  assign shift_ok    = (digit <= BCD_MAX) && (sec_ones <= SEC_TENS_MAX) &&
                       (sec_tens <= MIN_MAX_D);
  assign zero        = (min_ones == '0) && (sec_tens == '0) && (sec_ones == '0);
  assign dec_to_zero = (min_ones == '0) && (sec_tens == '0) && (sec_ones == 4'd1);

  always_ff @(posedge clk) begin
    if (clear || clr_en) begin
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
    end else if (shift_en && shift_ok) begin
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= digit;
    end else if (dec_en) begin
      if (sec_ones != '0) begin
        sec_ones <= sec_ones - 4'd1;
      end else begin
        sec_ones <= BCD_MAX;
        if (sec_tens != '0) begin
          sec_tens <= sec_tens - 4'd1;
        end else begin
          sec_tens <= SEC_TENS_MAX;
          min_ones <= min_ones - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/microwave_controller.sv
// Microwave cook-timer sequencer: keypad entry, start/stop/pause/door FSM, 1 Hz countdown.
// Define MICROWAVE_ALARM_EN to hold done for DONE_TICKS ticks instead of a one-clock pulse.
module microwave_controller
  import microwave_pkg::*;
#(
  parameter int unsigned DONE_TICKS = 3,
  parameter int unsigned MAX_MIN    = 9
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       load,
  input  logic       pgt_1Hz,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state_o
);

  if (DONE_TICKS < 1 || MAX_MIN > 9) begin : g_bad_param
    $error("microwave_controller: DONE_TICKS must be >= 1 and MAX_MIN <= 9");
  end

  state_t state, next_state;
  logic   load_d, tick_d, load_rise, tick_rise;
  logic   clr_en, shift_en, dec_en;
  logic   shift_ok, zero, dec_to_zero;

  bcd_time_reg #(.MAX_MIN(MAX_MIN)) u_time (
    .clk         (clk),
    .clear       (clear),
    .clr_en      (clr_en),
    .shift_en    (shift_en),
    .digit       (D),
    .dec_en      (dec_en),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .shift_ok    (shift_ok),
    .zero        (zero),
    .dec_to_zero (dec_to_zero)
  );

`ifdef MICROWAVE_ALARM_EN
  localparam int unsigned CNT_W = $clog2(DONE_TICKS + 1);
  logic [CNT_W-1:0] done_cnt;
  logic             last_tick;

  assign last_tick = (done_cnt == CNT_W'(DONE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (clear || state != DONE) begin
      done_cnt <= '0;
    end else if (tick_rise) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      mag_on    <= 1'b0;
      done      <= 1'b0;
      load_d    <= 1'b0;
      tick_d    <= 1'b0;
      load_rise <= 1'b0;
      tick_rise <= 1'b0;
    end else begin
      state     <= next_state;
      mag_on    <= (next_state == COOK);
`ifdef MICROWAVE_ALARM_EN
      done      <= (next_state == DONE);
`else
      done      <= (next_state == DONE) && (state != DONE);
`endif
      load_d    <= load;
      tick_d    <= pgt_1Hz;
      load_rise <= load & ~load_d;
      tick_rise <= pgt_1Hz & ~tick_d;
    end
  end

  // Priority stop > door open > start > tick; keys only act in IDLE.
  always_comb begin
    next_state = state;
    clr_en     = 1'b0;
    shift_en   = 1'b0;
    dec_en     = 1'b0;
    case (state)
      IDLE: begin
        if (stop) begin
          clr_en = 1'b1;
        end else if (start && door_closed && !zero) begin
          next_state = COOK;
        end else if (load_rise) begin
          shift_en = 1'b1;
        end
      end
      COOK: begin
        if (stop || !door_closed) begin
          next_state = PAUSED;
        end else if (tick_rise) begin
          dec_en = 1'b1;
          if (dec_to_zero) next_state = DONE;
        end
      end
      PAUSED: begin
        if (stop) begin
          clr_en     = 1'b1;
          next_state = IDLE;
        end else if (start && door_closed) begin
          next_state = COOK;
        end
      end
      DONE: begin
`ifdef MICROWAVE_ALARM_EN
        if (stop || load_rise || (tick_rise && last_tick)) next_state = IDLE;
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_microwave_controller.sv
// Testbench for microwave_controller: directed vector table, hand-written corner
// sequences and random stimulus, all checked against a seconds-based reference model.
module tb_microwave_controller;

  localparam int unsigned MAX_MIN    = 9;
  localparam int unsigned DONE_TICKS = 3;

  localparam int OP_KEY = 0, OP_START = 1, OP_STOP = 2, OP_TICK = 3,
                 OP_DOOR = 4, OP_DOOR_TICK = 5;

  logic       clk = 1'b0;
  logic       clear, load, pgt_1Hz, start, stop, door_closed;
  logic [3:0] D;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       mag_on, done;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  microwave_controller #(.DONE_TICKS(DONE_TICKS), .MAX_MIN(MAX_MIN)) dut (
    .clk         (clk),
    .clear       (clear),
    .D           (D),
    .load        (load),
    .pgt_1Hz     (pgt_1Hz),
    .start       (start),
    .stop        (stop),
    .door_closed (door_closed),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .mag_on      (mag_on),
    .done        (done),
    .state_o     (state_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check_vec(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {m,t,o,st,mag,done}=%h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {min_ones, sec_tens, sec_ones, state_o, mag_on, done};
  endfunction

  // Reference model: time kept as total seconds, state as 0..3.
  int m_secs = 0, m_state = 0, m_cnt = 0;
  bit m_mag = 0, m_done = 0, m_load_d = 0, m_tick_d = 0, m_lr = 0, m_tr = 0;
  bit chk_en = 0;

  task automatic model_shift(input int d);
    int st, so;
    st = (m_secs % 60) / 10;
    so = m_secs % 10;
    if (d <= 9 && so <= 5 && st <= int'(MAX_MIN)) m_secs = st * 60 + so * 10 + d;
  endtask

  task automatic model_step();
    bit lr, tr;
    int prev;
    lr   = m_lr;
    tr   = m_tr;
    prev = m_state;
    if (clear) begin
      m_secs = 0; m_state = 0; m_cnt = 0; m_mag = 0; m_done = 0;
      m_load_d = 0; m_tick_d = 0; m_lr = 0; m_tr = 0;
      return;
    end
    m_lr = load && !m_load_d;     m_load_d = load;
    m_tr = pgt_1Hz && !m_tick_d;  m_tick_d = pgt_1Hz;
    case (prev)
      0: if (stop) m_secs = 0;
         else if (start && door_closed && m_secs != 0) m_state = 1;
         else if (lr) model_shift(int'(D));
      1: if (stop || !door_closed) m_state = 2;
         else if (tr) begin
           m_secs = m_secs - 1;
           if (m_secs == 0) m_state = 3;
         end
      2: if (stop) begin m_state = 0; m_secs = 0; end
         else if (start && door_closed) m_state = 1;
      default: begin
`ifdef MICROWAVE_ALARM_EN
        if (stop || lr) m_state = 0;
        else if (tr) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == int'(DONE_TICKS)) m_state = 0;
        end
`else
        m_state = 0;
`endif
      end
    endcase
    if (m_state == 3 && prev != 3) m_cnt = 0;
    m_mag = (m_state == 1);
`ifdef MICROWAVE_ALARM_EN
    m_done = (m_state == 3);
`else
    m_done = (m_state == 3) && (prev != 3);
`endif
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    if (chk_en)
      check_vec("model", dut_vec(),
                {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
                 2'(m_state), m_mag, m_done});
  end

  task automatic press(input int d);
    @(negedge clk); D = 4'(d); load = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); pgt_1Hz = 1'b1;
      repeat (2) @(negedge clk);
      pgt_1Hz = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  // Tick edge detected in the same cycle the door opens: pause wins, tick dropped.
  task automatic door_tick();
    @(negedge clk); pgt_1Hz = 1'b1;
    @(negedge clk); door_closed = 1'b0;
    @(negedge clk); pgt_1Hz = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          op;
    int          arg;
    logic [11:0] t;
    logic [1:0]  st;
    logic        mag;
  } vec_t;

  vec_t tab[$];

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      case (tab[i].op)
        OP_KEY:   press(tab[i].arg);
        OP_START: pulse_start();
        OP_STOP:  pulse_stop();
        OP_TICK:  tick(tab[i].arg);
        OP_DOOR:  begin @(negedge clk); door_closed = 1'(tab[i].arg); @(negedge clk); end
        default:  door_tick();
      endcase
      check_vec($sformatf("row%0d", i), dut_vec(), {tab[i].t, tab[i].st, tab[i].mag, 1'b0});
    end
  endtask

  initial begin
    // Entry, shift rejection, then cook 1:00 down to 0:01.
    tab.push_back('{OP_KEY,   1,  12'h001, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   3,  12'h013, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   0,  12'h130, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   5,  12'h305, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   12, 12'h305, 2'd0, 1'b0});
    tab.push_back('{OP_STOP,  0,  12'h000, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   1,  12'h001, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   3,  12'h013, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   0,  12'h130, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   7,  12'h307, 2'd0, 1'b0});
    tab.push_back('{OP_STOP,  0,  12'h000, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   1,  12'h001, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   0,  12'h010, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   0,  12'h100, 2'd0, 1'b0});
    tab.push_back('{OP_START, 0,  12'h100, 2'd1, 1'b1});
    tab.push_back('{OP_TICK,  1,  12'h059, 2'd1, 1'b1});
    tab.push_back('{OP_TICK,  58, 12'h001, 2'd1, 1'b1});
    // Door interlock, stop handling, start at zero, seconds-tens overflow reject.
    tab.push_back('{OP_KEY,   1,  12'h001, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   0,  12'h010, 2'd0, 1'b0});
    tab.push_back('{OP_START, 0,  12'h010, 2'd1, 1'b1});
    tab.push_back('{OP_DOOR_TICK, 0, 12'h010, 2'd2, 1'b0});
    tab.push_back('{OP_DOOR,  1,  12'h010, 2'd2, 1'b0});
    tab.push_back('{OP_START, 0,  12'h010, 2'd1, 1'b1});
    tab.push_back('{OP_TICK,  1,  12'h009, 2'd1, 1'b1});
    tab.push_back('{OP_STOP,  0,  12'h009, 2'd2, 1'b0});
    tab.push_back('{OP_STOP,  0,  12'h000, 2'd0, 1'b0});
    tab.push_back('{OP_START, 0,  12'h000, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   7,  12'h007, 2'd0, 1'b0});
    tab.push_back('{OP_KEY,   1,  12'h007, 2'd0, 1'b0});
    tab.push_back('{OP_STOP,  0,  12'h000, 2'd0, 1'b0});

    D = '0; load = 1'b0; pgt_1Hz = 1'b0; start = 1'b0; stop = 1'b0;
    door_closed = 1'b1; clear = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_vec("reset", dut_vec(), 16'h0000);

    run_rows(0, 16);

    // Final tick: 0:01 -> 0:00 enters DONE in the same edge.
    @(negedge clk); pgt_1Hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_vec("done_entry", dut_vec(), {12'h000, 2'd3, 1'b0, 1'b1});
    pgt_1Hz = 1'b0;
    @(negedge clk);
`ifdef MICROWAVE_ALARM_EN
    check_vec("done_hold", dut_vec(), {12'h000, 2'd3, 1'b0, 1'b1});
    for (int k = 1; k <= int'(DONE_TICKS); k++) begin
      tick(1);
      if (k < int'(DONE_TICKS))
        check_vec($sformatf("done_tick%0d", k), dut_vec(), {12'h000, 2'd3, 1'b0, 1'b1});
      else
        check_vec("done_exit", dut_vec(), {12'h000, 2'd0, 1'b0, 1'b0});
    end
`else
    check_vec("done_pulse", dut_vec(), {12'h000, 2'd0, 1'b0, 1'b0});
`endif

    run_rows(17, 29);

    // clear while cooking at 2:15.
    press(2); press(1); press(5);
    pulse_start();
    check_vec("cook_215", dut_vec(), {12'h215, 2'd1, 1'b1, 1'b0});
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check_vec("clear_mid_cook", dut_vec(), 16'h0000);

    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      load        = ($urandom_range(3) == 0);
      D           = 4'($urandom_range(15));
      start       = ($urandom_range(7) == 0);
      stop        = ($urandom_range(63) == 0);
      door_closed = ($urandom_range(15) != 0);
      if ($urandom_range(3) == 0) pgt_1Hz = ~pgt_1Hz;
      clear       = ($urandom_range(999) == 0);
    end
    @(negedge clk);
    clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
